mem_miss_sched: RTL and testbench
=================================

MEM_MISS_SCHED -- requirements
Module: mem_miss_sched

Interface
REQ-001 Parameter ENTRIES, default 4, SHALL set the number of outstanding-miss slots.
REQ-002 Parameter LAT_W, default 5, SHALL set the width of the miss-latency countdown.
REQ-003 clk  in  1  SHALL be the single clock for the block.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 alloc_valid_i  in  1  SHALL mark a miss (negative feedback) from the mem unit.
REQ-006 alloc_warpID_i  in  3  SHALL carry the warp ID of the miss.
REQ-007 alloc_scbID_i  in  2  SHALL carry the scoreboard ID of the miss.
REQ-008 alloc_latency_i  in  LAT_W  SHALL carry the miss latency in cycles.
REQ-009 alloc_ready_o  out  1  SHALL assert when at least one slot is FREE.
REQ-010 replay_valid_o  out  1  SHALL assert when a READY slot is offered for re-issue.
REQ-011 replay_warpID_o  out  3  SHALL carry the warp ID of the offered slot.
REQ-012 replay_scbID_o  out  2  SHALL carry the scoreboard ID of the offered slot.
REQ-013 replay_ready_i  in  1  SHALL indicate that the issue stage accepts the replay.
REQ-014 flush_valid_i  in  1  SHALL request removal of a warp's slots.
REQ-015 flush_warpID_i  in  3  SHALL identify the warp to remove.
REQ-016 count_o  out  $clog2(ENTRIES)+1  SHALL report the number of non-FREE slots.
REQ-017 drop_o  out  1  SHALL pulse for one cycle when an alloc is rejected.

Function
REQ-018 Each slot SHALL hold a state (FREE, WAIT or READY), warpID, scbID and a LAT_W countdown.
REQ-019 Alloc SHALL occur when alloc_valid_i=1 and alloc_ready_o=1; it SHALL fill the lowest-index FREE slot with state WAIT and countdown=max(alloc_latency_i,1).
REQ-020 A WAIT slot SHALL decrement each cycle and move to READY on the edge where the countdown is 1, so READY is visible exactly max(L,1) cycles after the alloc edge.
REQ-021 Replay outputs SHALL be combinational from registered state; replay_valid_o=1 when any slot is READY.
REQ-022 Selection SHALL be round-robin among READY slots, starting at the index after the last granted slot (pointer 0 after reset).
REQ-023 The offered slot SHALL stay stable while replay_valid_o=1 and replay_ready_i=0, unless it is flushed.
REQ-024 On the handshake (valid and ready), the slot SHALL become FREE on the next edge and the RR pointer SHALL advance past it.
REQ-025 alloc_ready_o SHALL depend only on current state, so a slot freed in the same cycle is not reusable until the next cycle.
REQ-026 Alloc while alloc_ready_o=0 SHALL be discarded, and drop_o SHALL be 1 on the next cycle.
REQ-027 Flush SHALL free every WAIT/READY slot whose warpID matches, on the next edge.
REQ-028 An alloc in the same cycle as a flush SHALL be accepted even if it matches the flushed warp.
REQ-029 A handshake on a slot being flushed SHALL count as issued, and the slot SHALL be FREE.
REQ-030 Duplicate warpID/scbID pairs SHALL be allowed in separate slots.
REQ-031 count_o SHALL be registered and equal the number of non-FREE slots after the edge.

Reset
REQ-032 While rst=0 at an edge: all slots FREE, RR pointer 0, count_o=0, drop_o=0, replay_valid_o=0, alloc_ready_o=1.
REQ-033 Reset mid-countdown SHALL discard all slots with no replay emitted.

Structure
REQ-034 ENTRIES, LAT_W, the slot-state encoding and the warp/scb ID widths SHALL live in shared package mem_pkg.
REQ-035 Round-robin selection SHALL be the sub-module mem_rr_arb (ENTRIES-way, request vector plus pointer in, one-hot grant out).

Verification
REQ-036 Alloc warp 3, scb 1, L=4 at cycle 0 with replay_ready_i=1 -> replay_valid_o=1 in cycle 4 only, with warpID=3 and scbID=1; count_o returns to 0.
REQ-037 Five allocs on consecutive cycles with L=20 -> slots 0-3 filled, alloc_ready_o=0, fifth alloc gives drop_o=1, count_o=4.
REQ-038 Slots 0, 1, 2 READY with replay_ready_i=1 held -> grants in order 0, 1, 2 on consecutive cycles; a re-alloc into slot 0 becoming READY is granted after 2.
REQ-039 Slots 0 and 2 (warp 5) WAIT and slot 1 (warp 2) WAIT; flush warp 5 -> count_o=1 and only warp 2 replays.
REQ-040 Alloc with L=0 -> READY after 1 cycle; replay_ready_i=0 for 3 cycles -> outputs stable, then handshake frees the slot.
REQ-041 rst=0 asserted with 2 slots WAIT -> after the edge count_o=0, and no replay_valid_o within the next 32 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, defaults and slot-state encoding for the memory-miss replay scheduler.
package mem_pkg;
  localparam int ENTRIES_DEF = 4;
  localparam int LAT_W_DEF   = 5;
  localparam int WARP_W      = 3;
  localparam int SCB_W       = 2;

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_READY = 2'd2
  } slot_st_e;
endpackage

// File: rtl/mem_miss_sched_if.sv
// Alloc / replay / flush handshake bundle between the mem unit, issue stage and scheduler.
interface mem_miss_sched_if import mem_pkg::*; #(parameter int LAT_W = LAT_W_DEF) ();
  logic              alloc_valid_i;
  logic [WARP_W-1:0] alloc_warpID_i;
  logic [SCB_W-1:0]  alloc_scbID_i;
  logic [LAT_W-1:0]  alloc_latency_i;
  logic              alloc_ready_o;
  logic              replay_valid_o;
  logic [WARP_W-1:0] replay_warpID_o;
  logic [SCB_W-1:0]  replay_scbID_o;
  logic              replay_ready_i;
  logic              flush_valid_i;
  logic [WARP_W-1:0] flush_warpID_i;

  modport slave (
    input  alloc_valid_i, alloc_warpID_i, alloc_scbID_i, alloc_latency_i,
    output alloc_ready_o,
    output replay_valid_o, replay_warpID_o, replay_scbID_o,
    input  replay_ready_i,
    input  flush_valid_i, flush_warpID_i
  );

  modport master (
    output alloc_valid_i, alloc_warpID_i, alloc_scbID_i, alloc_latency_i,
    input  alloc_ready_o,
    input  replay_valid_o, replay_warpID_o, replay_scbID_o,
    output replay_ready_i,
    output flush_valid_i, flush_warpID_i
  );
endinterface

// File: rtl/mem_rr_arb.sv
// Round-robin picker: first requester at or after ptr_i (wrapping), one-hot grant.
module mem_rr_arb #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic [ENTRIES-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [ENTRIES-1:0] gnt_o
);
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < ENTRIES; k++) begin
      if (!found && req_i[(int'(ptr_i) + k) % ENTRIES]) begin
        gnt_o[(int'(ptr_i) + k) % ENTRIES] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_miss_sched.sv
// Holds outstanding memory misses, counts down their latency and replays them round-robin.
module mem_miss_sched import mem_pkg::*; #(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int LAT_W   = LAT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  mem_miss_sched_if.slave          bus,
  output logic [$clog2(ENTRIES):0] count_o,
  output logic                     drop_o
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W = $clog2(ENTRIES) + 1;

  slot_st_e                       st_q [ENTRIES];
  slot_st_e                       st_d [ENTRIES];
  logic [ENTRIES-1:0][WARP_W-1:0] warp_q, warp_d;
  logic [ENTRIES-1:0][SCB_W-1:0]  scb_q, scb_d;
  logic [ENTRIES-1:0][LAT_W-1:0]  lat_q, lat_d;
  logic [IDX_W-1:0]               ptr_q, ptr_d, lock_idx_q, lock_idx_d;
  logic                           lock_q, lock_d, drop_q;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [ENTRIES-1:0]             rdy_vec, free_vec, gnt;
  logic [IDX_W-1:0]               sel_idx, alloc_idx;
  logic                           hs, alloc_fire;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      rdy_vec[i]  = (st_q[i] == SLOT_READY);
      free_vec[i] = (st_q[i] == SLOT_FREE);
    end
  end

  mem_rr_arb #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_arb (
    .req_i (rdy_vec),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // A stalled offer is pinned so a newly READY slot cannot steal it before the handshake.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (gnt[i]) sel_idx = IDX_W'(i);
    if (lock_q && rdy_vec[lock_idx_q]) sel_idx = lock_idx_q;
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (free_vec[i]) alloc_idx = IDX_W'(i);
  end

  assign bus.alloc_ready_o   = |free_vec;
  assign bus.replay_valid_o  = |rdy_vec;
  assign bus.replay_warpID_o = warp_q[sel_idx];
  assign bus.replay_scbID_o  = scb_q[sel_idx];
  assign hs         = bus.replay_valid_o && bus.replay_ready_i;
  assign alloc_fire = bus.alloc_valid_i && bus.alloc_ready_o;

  always_comb begin
    warp_d  = warp_q;
    scb_d   = scb_q;
    lat_d   = lat_q;
    count_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      st_d[i] = st_q[i];
      if (hs && sel_idx == IDX_W'(i)) begin
        st_d[i] = SLOT_FREE;
      end else if (bus.flush_valid_i && st_q[i] != SLOT_FREE &&
                   warp_q[i] == bus.flush_warpID_i) begin
        st_d[i] = SLOT_FREE;
      end else if (st_q[i] == SLOT_WAIT) begin
        if (lat_q[i] == LAT_W'(1)) st_d[i] = SLOT_READY;
        else                       lat_d[i] = lat_q[i] - LAT_W'(1);
      end
      // Only FREE slots are filled, so an alloc never collides with flush or replay.
      if (alloc_fire && alloc_idx == IDX_W'(i)) begin
        st_d[i]   = SLOT_WAIT;
        warp_d[i] = bus.alloc_warpID_i;
        scb_d[i]  = bus.alloc_scbID_i;
        lat_d[i]  = (bus.alloc_latency_i == '0) ? LAT_W'(1) : bus.alloc_latency_i;
      end
      if (st_d[i] != SLOT_FREE) count_d = count_d + CNT_W'(1);
    end
    ptr_d      = ptr_q;
    if (hs) ptr_d = (sel_idx == IDX_W'(ENTRIES - 1)) ? '0 : sel_idx + IDX_W'(1);
    lock_d     = bus.replay_valid_o && !bus.replay_ready_i;
    lock_idx_d = sel_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) st_q[i] <= SLOT_FREE;
      warp_q     <= '0;
      scb_q      <= '0;
      lat_q      <= '0;
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) st_q[i] <= st_d[i];
      warp_q     <= warp_d;
      scb_q      <= scb_d;
      lat_q      <= lat_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      count_q    <= count_d;
      drop_q     <= bus.alloc_valid_i && !bus.alloc_ready_o;
    end
  end

  assign count_o = count_q;
  assign drop_o  = drop_q;
endmodule

// File: tb/tb_mem_miss_sched.sv
// Directed bench for mem_miss_sched: hand-computed expectations checked with immediate assertions.
module tb_mem_miss_sched;
  import mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] count;
  logic       drop;
  int         nchk = 0;
  int         nerr = 0;
  logic       seen;

  mem_miss_sched_if #(.LAT_W(5)) bus ();

  mem_miss_sched #(.ENTRIES(4), .LAT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .count_o (count),
    .drop_o  (drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic alloc(input logic [2:0] w, input logic [1:0] s, input logic [4:0] l);
    bus.alloc_valid_i   = 1'b1;
    bus.alloc_warpID_i  = w;
    bus.alloc_scbID_i   = s;
    bus.alloc_latency_i = l;
  endtask

  task automatic flush(input logic [2:0] w);
    bus.flush_valid_i  = 1'b1;
    bus.flush_warpID_i = w;
  endtask

  task automatic idle();
    bus.alloc_valid_i = 1'b0;
    bus.flush_valid_i = 1'b0;
  endtask

  initial begin
    bus.alloc_valid_i   = 1'b0;
    bus.alloc_warpID_i  = '0;
    bus.alloc_scbID_i   = '0;
    bus.alloc_latency_i = '0;
    bus.replay_ready_i  = 1'b0;
    bus.flush_valid_i   = 1'b0;
    bus.flush_warpID_i  = '0;

    // reset state
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_drop", drop, 0);
    chk("rst_rvalid", bus.replay_valid_o, 0);
    chk("rst_aready", bus.alloc_ready_o, 1);
    rst = 1'b1;

    // single miss, L=4, replay exactly four edges after the alloc edge
    bus.replay_ready_i = 1'b1;
    alloc(3, 1, 4); tick(); idle();
    chk("t1_count_alloc", count, 1);
    chk("t1_rvalid_e0", bus.replay_valid_o, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_rvalid_early", bus.replay_valid_o, 0);
    end
    tick();
    chk("t1_rvalid_e4", bus.replay_valid_o, 1);
    chk("t1_warp", bus.replay_warpID_o, 3);
    chk("t1_scb", bus.replay_scbID_o, 1);
    tick();
    chk("t1_rvalid_e5", bus.replay_valid_o, 0);
    chk("t1_count_end", count, 0);

    // fill all four slots, fifth alloc dropped
    bus.replay_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alloc(3'(i), 0, 20); tick();
    end
    chk("t2_count_full", count, 4);
    chk("t2_aready_full", bus.alloc_ready_o, 0);
    chk("t2_drop_before", drop, 0);
    alloc(4, 0, 20); tick(); idle();
    chk("t2_drop", drop, 1);
    chk("t2_count_after_drop", count, 4);
    tick();
    chk("t2_drop_pulse", drop, 0);
    for (int i = 0; i < 4; i++) begin
      flush(3'(i)); tick();
    end
    idle();
    chk("t2_count_flushed", count, 0);
    chk("t2_aready_flushed", bus.alloc_ready_o, 1);

    // reset mid-countdown discards slots
    alloc(0, 0, 10); tick();
    alloc(1, 1, 10); tick(); idle();
    tick();
    rst = 1'b0; tick();
    chk("t3_rst_count", count, 0);
    chk("t3_rst_rvalid", bus.replay_valid_o, 0);
    chk("t3_rst_aready", bus.alloc_ready_o, 1);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (bus.replay_valid_o) seen = 1'b1;
    end
    chk("t3_no_replay", seen, 0);

    // round-robin 0,1,2 then re-allocated slot 0 after 2
    bus.replay_ready_i = 1'b1;
    alloc(1, 0, 3); tick();
    alloc(2, 1, 2); tick();
    alloc(3, 2, 1); tick(); idle();
    chk("t4_rvalid_pre", bus.replay_valid_o, 0);
    tick();
    chk("t4_g0_warp", bus.replay_warpID_o, 1);
    chk("t4_g0_count", count, 3);
    tick();
    chk("t4_g1_warp", bus.replay_warpID_o, 2);
    chk("t4_g1_count", count, 2);
    alloc(6, 2, 1); tick(); idle();
    chk("t4_g2_warp", bus.replay_warpID_o, 3);
    chk("t4_g2_count", count, 2);
    tick();
    chk("t4_g3_warp", bus.replay_warpID_o, 6);
    chk("t4_g3_scb", bus.replay_scbID_o, 2);
    chk("t4_g3_count", count, 1);
    tick();
    chk("t4_rvalid_end", bus.replay_valid_o, 0);
    chk("t4_count_end", count, 0);

    // flush warp 5 out of slots 0 and 2; warp 2 in slot 1 survives
    alloc(5, 0, 10); tick();
    alloc(2, 1, 3); tick();
    alloc(5, 2, 10); tick();
    idle(); flush(5); tick(); idle();
    chk("t5_count_flush", count, 1);
    chk("t5_rvalid_pre", bus.replay_valid_o, 0);
    tick();
    chk("t5_rvalid", bus.replay_valid_o, 1);
    chk("t5_warp", bus.replay_warpID_o, 2);
    tick();
    chk("t5_count_end", count, 0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.replay_valid_o) seen = 1'b1;
    end
    chk("t5_no_warp5", seen, 0);

    // L=0 behaves as 1; outputs hold while stalled
    bus.replay_ready_i = 1'b0;
    alloc(4, 3, 0); tick(); idle();
    chk("t6_rvalid_e0", bus.replay_valid_o, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_stall_valid", bus.replay_valid_o, 1);
      chk("t6_stall_warp", bus.replay_warpID_o, 4);
      chk("t6_stall_scb", bus.replay_scbID_o, 3);
    end
    bus.replay_ready_i = 1'b1;
    tick();
    chk("t6_rvalid_done", bus.replay_valid_o, 0);
    chk("t6_count_done", count, 0);

    // alloc alongside a same-warp flush is kept; handshake on a flushed slot frees it
    alloc(5, 0, 2); flush(5); tick(); idle();
    chk("t7_alloc_flush_count", count, 1);
    tick(); tick();
    chk("t7_rvalid", bus.replay_valid_o, 1);
    chk("t7_warp", bus.replay_warpID_o, 5);
    flush(5); tick(); idle();
    chk("t7_count_end", count, 0);
    chk("t7_rvalid_end", bus.replay_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
